// File: rtl/write_back_buffer.sv
// write_back_buffer: in-order write-back queue between the EX/WB register and
// the register-file write port. Completed results that write a register are
// held in a circular queue until the register file accepts them. Results with
// no register write are dropped at the input. A combinational forwarding
// lookup returns the newest pending entry for a requested register.
module write_back_buffer #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // EX/WB side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wen,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [REG_W-1:0]         in_reg,
  // register-file side
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [REG_W-1:0]         wb_reg,
  // forwarding lookup
  input  logic [REG_W-1:0]         fwd_reg,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  // occupancy
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [REG_W-1:0]  reg_q  [DEPTH];

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  head_d;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  tail_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // Full check depends on the occupancy register only, so a pop in the same
  // cycle never lets a full queue accept.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign wb_valid = (count_q != {CNT_W{1'b0}});
  assign accept_s = in_valid & in_ready;
  // A completed transfer with no register write is consumed but not stored.
  assign push_s   = accept_s & in_wen;
  assign pop_s    = wb_valid & wb_ready;
  assign count    = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: cleared on reset, written at the tail on a push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
        reg_q[i]  <= {REG_W{1'b0}};
      end
    end else if (push_s) begin
      data_q[tail_q] <= in_data;
      reg_q[tail_q]  <= in_reg;
    end
  end

  // Head entry presented to the register file; zero when nothing is pending.
  always_comb begin
    wb_data = {DATA_W{1'b0}};
    wb_reg  = {REG_W{1'b0}};
    if (wb_valid) begin
      wb_data = data_q[head_q];
      wb_reg  = reg_q[head_q];
    end else begin
      wb_data = {DATA_W{1'b0}};
      wb_reg  = {REG_W{1'b0}};
    end
  end

  // Forwarding: walk pending entries oldest to newest so the last match, the
  // newest pending write to fwd_reg, wins. The head entry is still searched
  // while it is being popped because the register file is not yet updated.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (reg_q[head_q + PTR_W'(i)] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PTR_W'(i)];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end

endmodule
